// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and next-PC sequencer with run control and a call/return stack
module pc_fetch_ctrl #(
  parameter int D     = 12,
  parameter int A     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         halt_en,
  input  logic         ret_en,
  input  logic         call_en,
  input  logic         jump_en,
  input  logic         branch_en,
  input  logic         branch_cond,
  input  logic [A-1:0] jump_sel,
  input  logic [D-1:0] lut_target,
  output logic [A-1:0] lut_addr,
  output logic [D-1:0] prog_ctr,
  output logic         done,
  output logic         stack_err
);
  localparam int SW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state, state_n;
  logic [SW-1:0] sp, sp_n;
  logic [D-1:0]  pc_n, pc_inc, top;
  logic          err_n, push;
  logic [D-1:0]  stk [DEPTH];
  assign lut_addr = jump_sel;
  assign done     = state == DONE;
  assign pc_inc   = prog_ctr + D'(1);
  // top-of-stack entry, i.e. the slot just below sp
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sp == SW'(i + 1)) top = stk[i];
  end
  // next-state and datapath selection; the first matching control wins
  always_comb begin
    state_n = state;
    pc_n    = prog_ctr;
    sp_n    = sp;
    err_n   = stack_err;
    push    = 1'b0;
    case (state)
      IDLE: state_n = start ? RUN : IDLE;
      RUN: begin
        if (stall) begin
          state_n = RUN;
        end else if (halt_en) begin
          state_n = DONE;
        end else if (ret_en) begin
          if (sp == '0) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else begin
            sp_n = sp - SW'(1);
            pc_n = top;
          end
        end else if (call_en) begin
          if (sp == SW'(DEPTH)) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else begin
            push = 1'b1;
            sp_n = sp + SW'(1);
            pc_n = lut_target;
          end
        end else begin
          pc_n = (jump_en || (branch_en && branch_cond)) ? lut_target : pc_inc;
        end
      end
      default: begin
        if (start) begin
          state_n = RUN;
          pc_n    = '0;
          sp_n    = '0;
          err_n   = 1'b0;
        end
      end
    endcase
  end
  // state, program counter, stack pointer and sticky error registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      prog_ctr  <= '0;
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      state     <= state_n;
      prog_ctr  <= pc_n;
      sp        <= sp_n;
      stack_err <= err_n;
    end
  end
  // return-address pushes land in the slot at the current sp
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
    end else if (push) begin
      for (int i = 0; i < DEPTH; i++)
        if (sp == SW'(i)) stk[i] <= pc_inc;
    end
  end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed and randomized checks of pc_fetch_ctrl against a reference model
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, stall = 1'b0, halt_en = 1'b0, ret_en = 1'b0, call_en = 1'b0;
  logic        jump_en = 1'b0, branch_en = 1'b0, branch_cond = 1'b0;
  logic [7:0]  jump_sel = '0;
  logic [11:0] lut_target = '0;
  logic [7:0]  lut_addr;
  logic [11:0] prog_ctr;
  logic        done, stack_err;
  int n_assert = 0, n_fail = 0;
  int m_st = 0;
  int m_pc = 0;
  bit m_err = 0;
  int q[$];

  pc_fetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_en(halt_en),
    .ret_en(ret_en), .call_en(call_en), .jump_en(jump_en), .branch_en(branch_en),
    .branch_cond(branch_cond), .jump_sel(jump_sel), .lut_target(lut_target),
    .lut_addr(lut_addr), .prog_ctr(prog_ctr), .done(done), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model();
    if (m_st == 0) begin
      if (start) begin m_st = 1; m_pc = 0; end
    end else if (m_st == 2) begin
      if (start) begin m_st = 1; m_pc = 0; q.delete(); m_err = 0; end
    end else if (!stall) begin
      if (halt_en) m_st = 2;
      else if (ret_en) begin
        if (q.size() == 0) begin m_err = 1; m_st = 2; end
        else m_pc = q.pop_back();
      end else if (call_en) begin
        if (q.size() == 4) begin m_err = 1; m_st = 2; end
        else begin q.push_back((m_pc + 1) % 4096); m_pc = int'(lut_target); end
      end else if (jump_en || (branch_en && branch_cond)) m_pc = int'(lut_target);
      else m_pc = (m_pc + 1) % 4096;
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".pc"}, 32'(prog_ctr), 32'(m_pc));
    chk({tag, ".done"}, 32'(done), 32'(m_st == 2));
    chk({tag, ".err"}, 32'(stack_err), 32'(m_err));
  endtask

  task automatic set_ctl(input bit s, input bit st, input bit h, input bit r, input bit c,
                         input bit j, input bit b, input bit bc, input int sel, input int tgt);
    start = s; stall = st; halt_en = h; ret_en = r; call_en = c;
    jump_en = j; branch_en = b; branch_cond = bc;
    jump_sel = 8'(sel); lut_target = 12'(tgt);
  endtask

  task automatic cyc(input string tag);
    #1;
    chk({tag, ".lut_addr"}, 32'(lut_addr), 32'(jump_sel));
    model();
    @(posedge clk);
    #1;
    check_outs(tag);
  endtask

  task automatic idle_c(input string tag);
    set_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(tag);
  endtask

  task automatic goto(input int pc);
    set_ctl(0, 0, 0, 0, 0, 1, 0, 0, 1, pc);
    cyc("goto");
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset");
    reset = 1'b1;
    set_ctl(0, 0, 0, 0, 1, 1, 0, 0, 5, 77);
    cyc("idle_ignore");
    set_ctl(1, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    cyc("start");
    for (int i = 1; i <= 5; i++) begin
      set_ctl(0, 0, 0, 0, 0, 0, 0, 0, i * 3, 0);
      cyc("seq");
    end
    goto(3);
    set_ctl(0, 0, 0, 0, 0, 1, 0, 0, 2, 285);
    cyc("jump");
    idle_c("after_jump");
    goto(10);
    set_ctl(0, 0, 0, 0, 0, 0, 1, 0, 4, 999);
    cyc("br_not_taken");
    goto(20);
    for (int i = 0; i < 3; i++) begin
      set_ctl(0, 1, 0, 0, 0, 0, 1, 1, 6, 35);
      cyc("br_stall");
    end
    set_ctl(0, 0, 0, 0, 0, 0, 1, 1, 6, 35);
    cyc("br_taken");
    set_ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("start_in_run");
    goto(7);
    set_ctl(0, 0, 0, 0, 1, 0, 0, 0, 1, 411);
    cyc("call");
    set_ctl(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("ret");
    cyc("ret_empty");
    set_ctl(0, 0, 0, 0, 0, 1, 0, 0, 3, 55);
    cyc("done_ignore");
    set_ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("restart1");
    for (int i = 1; i <= 5; i++) begin
      set_ctl(0, 0, 0, 0, 1, 0, 0, 0, i, i * 100);
      cyc("nest_call");
    end
    set_ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("restart2");
    goto(4095);
    idle_c("wrap");
    set_ctl(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("halt");
    for (int n = 0; n < 400; n++) begin
      set_ctl($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
              int'($urandom_range(0, 255)), int'($urandom_range(0, 4095)));
      cyc("rand");
    end
    set_ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("pre_reset");
    set_ctl(0, 0, 0, 0, 1, 0, 0, 0, 2, 999);
    #2;
    reset = 1'b0;
    #1;
    m_st = 0; m_pc = 0; m_err = 0; q.delete();
    check_outs("async_reset");
    @(posedge clk);
    #1;
    check_outs("held_reset");
    reset = 1'b1;
    set_ctl(0, 0, 0, 0, 0, 1, 0, 0, 2, 999);
    cyc("post_reset_idle");
    set_ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("post_reset_start");
    idle_c("post_reset_run");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
